// File: rtl/debug_port_arbiter_pkg.sv
// Shared definitions for the debug read-port arbiter: requester IDs,
// arbitration FSM states and default bus widths.
package debug_port_arbiter_pkg;

  localparam int unsigned DBG_ADDR_W = 7;
  localparam int unsigned DBG_DATA_W = 32;

  localparam logic REQ_AUX = 1'b0;
  localparam logic REQ_VGA = 1'b1;

  typedef enum logic {
    VGA_PRI   = 1'b0,
    AUX_BOOST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/debug_port_rsp_pipe.sv
// Two-stage response pipeline for the shared debug read port.
// Stage 1 registers the granted address/ID onto dbg_addr; stage 2 captures
// the read data and steers a one-cycle rvalid to the winning requester.
module debug_port_rsp_pipe
  import debug_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DBG_ADDR_W,
  parameter int unsigned DATA_W = DBG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt_vld,
  input  logic              gnt_id,
  input  logic [ADDR_W-1:0] gnt_addr,
  input  logic [DATA_W-1:0] cap_data,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata
);

  logic [ADDR_W-1:0] dbg_addr_q,   dbg_addr_d;
  logic              s1_vld_q,     s1_vld_d;
  logic              s1_id_q,      s1_id_d;
  logic              vga_rvalid_q, vga_rvalid_d;
  logic [DATA_W-1:0] vga_rdata_q,  vga_rdata_d;
  logic              aux_rvalid_q, aux_rvalid_d;
  logic [DATA_W-1:0] aux_rdata_q,  aux_rdata_d;

  // Next-state: address holds when idle, rdata holds while rvalid is low.
  always_comb begin
    dbg_addr_d   = gnt_vld ? gnt_addr : dbg_addr_q;
    s1_vld_d     = gnt_vld;
    s1_id_d      = gnt_vld ? gnt_id : s1_id_q;
    vga_rvalid_d = s1_vld_q && (s1_id_q == REQ_VGA);
    aux_rvalid_d = s1_vld_q && (s1_id_q == REQ_AUX);
    vga_rdata_d  = vga_rvalid_d ? cap_data : vga_rdata_q;
    aux_rdata_d  = aux_rvalid_d ? cap_data : aux_rdata_q;
  end

  // Pipeline registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_addr_q   <= '0;
      s1_vld_q     <= 1'b0;
      s1_id_q      <= REQ_AUX;
      vga_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
      aux_rvalid_q <= 1'b0;
      aux_rdata_q  <= '0;
    end else begin
      dbg_addr_q   <= dbg_addr_d;
      s1_vld_q     <= s1_vld_d;
      s1_id_q      <= s1_id_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
      aux_rvalid_q <= aux_rvalid_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

  assign dbg_addr   = dbg_addr_q;
  assign vga_rvalid = vga_rvalid_q;
  assign vga_rdata  = vga_rdata_q;
  assign aux_rvalid = aux_rvalid_q;
  assign aux_rdata  = aux_rdata_q;

endmodule

// File: rtl/debug_port_arbiter.sv
// Arbiter sharing the datapath debug read port between the VGA overlay
// (priority, burst lock) and an auxiliary probe (bounded starvation).
// Optional statistics counters: define DEBUG_PORT_ARB_STATS_EN.
module debug_port_arbiter
  import debug_port_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DBG_ADDR_W,
  parameter int unsigned       DATA_W     = DBG_DATA_W,
  parameter int unsigned       MAX_WAIT   = 16,
  parameter logic [ADDR_W-1:0] STATS_ADDR = ADDR_W'(7'h7F)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic              vga_lock,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  arb_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        vga_gnt_c, aux_gnt_c;
  logic        gnt_vld;
  logic        gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] cap_data;

  // Grant decode: VGA first normally, aux first when boosted; lock blocks aux.
  always_comb begin
    vga_gnt_c = 1'b0;
    aux_gnt_c = 1'b0;
    unique case (state_q)
      VGA_PRI: begin
        if (vga_req)                    vga_gnt_c = 1'b1;
        else if (aux_req && !vga_lock)  aux_gnt_c = 1'b1;
      end
      AUX_BOOST: begin
        if (aux_req && !vga_lock)       aux_gnt_c = 1'b1;
        else if (vga_req)               vga_gnt_c = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM and saturating aux wait counter next-state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      VGA_PRI: begin
        if (aux_req && !aux_gnt_c) begin
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
          if (wait_cnt_q >= MAX_WAIT_C) state_d = AUX_BOOST;
        end else begin
          wait_cnt_d = '0;
        end
      end
      AUX_BOOST: begin
        if (aux_gnt_c || !aux_req) begin
          wait_cnt_d = '0;
          state_d    = VGA_PRI;
        end
      end
      default: state_d = VGA_PRI;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= VGA_PRI;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign vga_gnt  = vga_gnt_c;
  assign aux_gnt  = aux_gnt_c;
  assign gnt_vld  = vga_gnt_c || aux_gnt_c;
  assign gnt_id   = vga_gnt_c ? REQ_VGA : REQ_AUX;
  assign gnt_addr = vga_gnt_c ? vga_addr : aux_addr;

`ifdef DEBUG_PORT_ARB_STATS_EN
  logic [15:0]       vga_gnt_cnt_q, vga_gnt_cnt_d;
  logic [15:0]       aux_gnt_cnt_q, aux_gnt_cnt_d;
  logic [DATA_W-1:0] stats_snap_q,  stats_snap_d;

  // Grant counters; the snapshot is taken at grant time so a stats read
  // reports only grants from earlier cycles, not itself.
  always_comb begin
    vga_gnt_cnt_d = vga_gnt_c ? vga_gnt_cnt_q + 16'd1 : vga_gnt_cnt_q;
    aux_gnt_cnt_d = aux_gnt_c ? aux_gnt_cnt_q + 16'd1 : aux_gnt_cnt_q;
    stats_snap_d  = gnt_vld ? DATA_W'({vga_gnt_cnt_q, aux_gnt_cnt_q}) : stats_snap_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_gnt_cnt_q <= '0;
      aux_gnt_cnt_q <= '0;
      stats_snap_q  <= '0;
    end else begin
      vga_gnt_cnt_q <= vga_gnt_cnt_d;
      aux_gnt_cnt_q <= aux_gnt_cnt_d;
      stats_snap_q  <= stats_snap_d;
    end
  end

  assign cap_data = (dbg_addr == STATS_ADDR) ? stats_snap_q : dbg_data;
`else
  logic unused_stats_addr;
  assign unused_stats_addr = ^STATS_ADDR;
  assign cap_data = dbg_data;
`endif

  debug_port_rsp_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rsp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id),
    .gnt_addr   (gnt_addr),
    .cap_data   (cap_data),
    .dbg_addr   (dbg_addr),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata)
  );

endmodule
